tca9539_i2c_master: RTL

//  I2C initiator for the TCA9539 register map. It issues single-register write and read

---
 rtl/tca9539_i2c_master.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/tca9539_i2c_master.sv
// -----------------------------------------------------------------------------
// tca9539_i2c_master
//   Single-register I2C initiator for the TCA9539 16-bit I/O expander.
//   Write: S,{DEV_ADDR,0},A,reg,A,data,A,P
//   Read : S,{DEV_ADDR,0},A,reg,A,Sr,{DEV_ADDR,1},A,data,NACK,P
//   Every bit slot is four quarters of CLK_DIV clocks: SCL is held low in
//   Q0-Q1 and released in Q2-Q3. SDA only moves at the start of Q0, except
//   inside START, RSTART and STOP.
//
// Ports
//   clk      system clock, all logic on posedge
//   rst      synchronous reset, active-high
//   start    transaction request, honoured only while busy=0
//   rw       1=read, 0=write (captured with start)
//   regAddr  register index (captured with start)
//   wrData   write byte (captured with start)
//   busy     transaction in progress
//   done     one-cycle pulse at transaction end
//   rdData   byte read, valid from done until the next accepted start
//   ackErr   slave NACKed an address/reg/data byte in the last transaction
//   sclOe    1 = pull SCL low
//   sdaOe    1 = pull SDA low
//   sclIn    SCL line level (clock-stretch detection)
//   sdaIn    SDA line level (ACK and read-data sampling)
// -----------------------------------------------------------------------------
module tca9539_i2c_master #(
   parameter int unsigned CLK_DIV  = 125,
   parameter logic [6:0]  DEV_ADDR = 7'h74
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       rw,
   input  logic [7:0] regAddr,
   input  logic [7:0] wrData,
   output logic       busy,
   output logic       done,
   output logic [7:0] rdData,
   output logic       ackErr,
   output logic       sclOe,
   output logic       sdaOe,
   input  logic       sclIn,
   input  logic       sdaIn
);

   localparam int unsigned CW     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CW-1:0] Q_LAST = CW'(CLK_DIV - 1);

   typedef enum logic [3:0] {
      IDLE, START, TX, RXACK, RSTART, RX, TXNACK, STOP, DONE
   } state_t;

   state_t state, stateNext;

   logic [CW-1:0] qCnt;
   logic [2:0]    quarter;     // 0..3 per bit, 0..7 for the two-bit STOP slot
   logic [2:0]    bitIdx;
   logic [1:0]    byteIdx;     // 0: address(W), 1: register, 2: data or address(R)
   logic [7:0]    txShift;
   logic [7:0]    rxShift;
   logic          rwLat;
   logic [7:0]    regLat;
   logic [7:0]    dataLat;
   logic          nackSeen;

   logic          idleLike;
   logic          accept;
   logic          quarterEnd;
   logic          lastQuarter;
   logic          hold;
   logic          bitEnd;
   logic          sampleNow;
   logic          ackBad;
   logic [7:0]    rxNext;
   logic [1:0]    byteNext;
   logic [7:0]    txByte;

   always_comb begin
      idleLike    = (state == IDLE) || (state == DONE);
      accept      = idleLike && start;
      quarterEnd  = (qCnt == Q_LAST);
      lastQuarter = (state == STOP) ? (quarter == 3'd7) : (quarter == 3'd3);
      sampleNow   = (quarter == 3'd3) && (qCnt == '0);

      sclOe = 1'b0;
      sdaOe = 1'b0;
      unique case (state)
         START: begin
            sclOe = quarter[1];
            sdaOe = 1'b1;
         end
         TX: begin
            sclOe = ~quarter[1];
            sdaOe = ~txShift[7];
         end
         RXACK, RX, TXNACK, RSTART: sclOe = ~quarter[1];
         STOP: begin
            sclOe = (quarter[2:1] == 2'd0);
            sdaOe = ~quarter[2];
         end
         default: ;
      endcase

      // Counter freezes on the first Q2 cycle while a slave stretches SCL.
      hold   = (quarter[1:0] == 2'd2) && (qCnt == '0) && !sclOe && !sclIn;
      bitEnd = !idleLike && quarterEnd && !hold && lastQuarter;

      // With CLK_DIV=1 the sample cycle is also the bit's last cycle, so the
      // live sdaIn is folded in rather than waiting for the registered copy.
      ackBad = sampleNow ? sdaIn : nackSeen;
      rxNext = sampleNow ? {rxShift[6:0], sdaIn} : rxShift;

      byteNext = (state == RXACK) ? byteIdx + 2'd1 : byteIdx;
      txByte   = '0;
      unique case (byteNext)
         2'd0:    txByte = {DEV_ADDR, 1'b0};
         2'd1:    txByte = regLat;
         default: txByte = rwLat ? {DEV_ADDR, 1'b1} : dataLat;
      endcase

      stateNext = state;
      unique case (state)
         IDLE:   if (start) stateNext = START;
         DONE:   stateNext = start ? START : IDLE;
         START:  if (bitEnd) stateNext = TX;
         TX:     if (bitEnd && bitIdx == 3'd7) stateNext = RXACK;
         RXACK: begin
            if (bitEnd) begin
               if (ackBad)              stateNext = STOP;
               else if (byteIdx == 2'd0) stateNext = TX;
               else if (byteIdx == 2'd1) stateNext = rwLat ? RSTART : TX;
               else                      stateNext = rwLat ? RX : STOP;
            end
         end
         RSTART: if (bitEnd) stateNext = START;
         RX:     if (bitEnd && bitIdx == 3'd7) stateNext = TXNACK;
         TXNACK: if (bitEnd) stateNext = STOP;
         STOP:   if (bitEnd) stateNext = DONE;
         default: stateNext = IDLE;
      endcase

      busy = !idleLike;
      done = (state == DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= stateNext;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         qCnt     <= '0;
         quarter  <= '0;
         bitIdx   <= '0;
         byteIdx  <= '0;
         txShift  <= '0;
         rxShift  <= '0;
         rwLat    <= 1'b0;
         regLat   <= '0;
         dataLat  <= '0;
         nackSeen <= 1'b0;
         ackErr   <= 1'b0;
         rdData   <= '0;
      end else if (accept) begin
         rwLat    <= rw;
         regLat   <= regAddr;
         dataLat  <= wrData;
         ackErr   <= 1'b0;
         byteIdx  <= '0;
         bitIdx   <= '0;
         qCnt     <= '0;
         quarter  <= '0;
         nackSeen <= 1'b0;
      end else if (idleLike) begin
         qCnt    <= '0;
         quarter <= '0;
      end else begin
         if (!hold) begin
            if (quarterEnd) begin
               qCnt    <= '0;
               quarter <= lastQuarter ? 3'd0 : quarter + 3'd1;
            end else begin
               qCnt <= qCnt + 1'b1;
            end
         end
         if (sampleNow) begin
            if (state == RXACK) nackSeen <= sdaIn;
            if (state == RX)    rxShift  <= {rxShift[6:0], sdaIn};
         end
         if (bitEnd) begin
            unique case (state)
               TX, RX: bitIdx <= bitIdx + 3'd1;   // wraps to 0 after bit 7
               RXACK: begin
                  byteIdx <= byteNext;
                  if (ackBad) ackErr <= 1'b1;
               end
               default: ;
            endcase
            // rdData only moves once all eight bits have been shifted in.
            if (state == RX && bitIdx == 3'd7) rdData <= rxNext;
            if (stateNext == TX)
               txShift <= (state == TX) ? {txShift[6:0], 1'b0} : txByte;
         end
      end
   end

endmodule
